// File: rtl/hazard_scoreboard_pkg.sv
// Shared types and latency defaults for the pending-latency hazard scoreboard.
package hazard_pkg;

  typedef enum logic [1:0] {
    LC_ALU  = 2'd0,
    LC_LOAD = 2'd1,
    LC_MUL  = 2'd2,
    LC_NONE = 2'd3
  } lat_class_e;

  localparam int ALU_LAT_DEF  = 1;
  localparam int LOAD_LAT_DEF = 2;
  localparam int MUL_LAT_DEF  = 3;

  function automatic int lat_of(input lat_class_e c,
                                input int alu_lat  = ALU_LAT_DEF,
                                input int load_lat = LOAD_LAT_DEF,
                                input int mul_lat  = MUL_LAT_DEF);
    case (c)
      LC_ALU:  return alu_lat;
      LC_LOAD: return load_lat;
      LC_MUL:  return mul_lat;
      default: return 0;
    endcase
  endfunction

endpackage

// File: rtl/hazard_scoreboard_entry.sv
// One scoreboard slot: saturating down-counter whose load wins over the decrement.
module hazard_sb_entry
  import hazard_pkg::*;
#(
  parameter int CNT_W = 3
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  output logic [CNT_W-1:0] o_cnt
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (i_load) begin
      cnt_d = i_load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign o_cnt = cnt_q;

endmodule

// File: rtl/hazard_scoreboard.sv
// ID-stage hazard scoreboard: per-register pending latency, MUL structural hazard, redirect squash.
// HAZARD_SB_FWD_EN defined: EX forwarding present; undefined: results are consumed from the RF.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int NUM_REGS      = 32,
  parameter int REG_AW        = 5,
  parameter int ALU_LAT       = ALU_LAT_DEF,
  parameter int LOAD_LAT      = LOAD_LAT_DEF,
  parameter int MUL_LAT       = MUL_LAT_DEF,
  parameter int CNT_W         = 3,
  parameter int MUL_PIPELINED = 0
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_id_valid,
  input  logic [REG_AW-1:0]   i_rs1,
  input  logic [REG_AW-1:0]   i_rs2,
  input  logic                i_use_rs1,
  input  logic                i_use_rs2,
  input  logic                i_is_branch,
  input  logic                i_is_jump,
  input  logic [REG_AW-1:0]   i_rd,
  input  logic                i_reg_write,
  input  lat_class_e          i_lat_class,
  input  logic                i_redirect,
  output logic                o_stall_if,
  output logic                o_stall_id,
  output logic                o_flush_id_ex,
  output logic                o_flush_if_id,
  output logic                o_mul_busy,
  output logic [NUM_REGS-1:0] o_pending
);

`ifdef HAZARD_SB_FWD_EN
  localparam int WB_ADJ = 0;
  localparam int EX_TH  = 1;
`else
  // Without forwarding a consumer must wait for the write-through RF, two stages later.
  localparam int WB_ADJ = 2;
  localparam int EX_TH  = 0;
`endif

  logic [NUM_REGS-1:0][CNT_W-1:0] cnt;
  logic [CNT_W-1:0]               mul_cnt;
  logic [CNT_W-1:0]               wr_val;
  logic                           issue, wr_en, mul_issue;
  logic                           ex_hz, br_dep, br_hz, st_hz, stall;

  assign cnt[0] = '0;

  assign wr_val    = CNT_W'(lat_of(i_lat_class, ALU_LAT, LOAD_LAT, MUL_LAT) + WB_ADJ);
  assign issue     = i_id_valid & ~stall;
  assign wr_en     = issue & i_reg_write & (i_rd != '0) & (i_lat_class != LC_NONE);
  assign mul_issue = issue & (i_lat_class == LC_MUL);

  for (genvar r = 1; r < NUM_REGS; r++) begin : g_ent
    hazard_sb_entry #(.CNT_W(CNT_W)) u_ent (
      .i_clk      (i_clk),
      .i_reset    (i_reset),
      .i_load     (wr_en && (i_rd == REG_AW'(r))),
      .i_load_val (wr_val),
      .o_cnt      (cnt[r])
    );
  end

  hazard_sb_entry #(.CNT_W(CNT_W)) u_mul (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_load     (mul_issue),
    .i_load_val (CNT_W'(MUL_LAT)),
    .o_cnt      (mul_cnt)
  );

  // x0 entry is constant zero, so rs==0 can never match a pending count.
  always_comb begin
    ex_hz  = (i_use_rs1 && (cnt[i_rs1] > CNT_W'(EX_TH))) ||
             (i_use_rs2 && (cnt[i_rs2] > CNT_W'(EX_TH)));
    br_dep = (i_use_rs1 && (cnt[i_rs1] != '0)) ||
             (i_use_rs2 && (cnt[i_rs2] != '0));
    br_hz  = (i_is_branch || i_is_jump) && br_dep;
    st_hz  = (MUL_PIPELINED == 0) && (i_lat_class == LC_MUL) && (mul_cnt > CNT_W'(1));
    stall  = i_id_valid && (ex_hz || br_hz || st_hz);
  end

  always_comb begin
    o_pending = '0;
    for (int r = 0; r < NUM_REGS; r++) begin
      o_pending[r] = (cnt[r] != '0);
    end
  end

  assign o_stall_if    = stall;
  assign o_stall_id    = stall;
  assign o_flush_id_ex = stall;
  assign o_flush_if_id = i_redirect & ~stall;
  assign o_mul_busy    = (mul_cnt != '0);

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard using an issue-timestamp reference model.
module tb_hazard_scoreboard;
  import hazard_pkg::*;

  localparam int NR = 32;
`ifdef HAZARD_SB_FWD_EN
  localparam int ADJ = 0;
  localparam int EXT = 1;
  localparam int E_LD_ALU = 1, E_ALU_BR = 1, E_LD_BR = 2, E_MUL_ALU = 2, E_WAW = 0;
`else
  localparam int ADJ = 2;
  localparam int EXT = 0;
  localparam int E_LD_ALU = 4, E_ALU_BR = 3, E_LD_BR = 4, E_MUL_ALU = 5, E_WAW = 3;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          id_valid, use_rs1, use_rs2, is_branch, is_jump, reg_write, redirect;
  logic [4:0]    rs1, rs2, rd;
  lat_class_e    lc;
  logic          stall_if, stall_id, flush_id_ex, flush_if_id, mul_busy;
  logic [NR-1:0] pending;

  always #5 clk = ~clk;

  hazard_scoreboard dut (
    .i_clk         (clk),
    .i_reset       (rst),
    .i_id_valid    (id_valid),
    .i_rs1         (rs1),
    .i_rs2         (rs2),
    .i_use_rs1     (use_rs1),
    .i_use_rs2     (use_rs2),
    .i_is_branch   (is_branch),
    .i_is_jump     (is_jump),
    .i_rd          (rd),
    .i_reg_write   (reg_write),
    .i_lat_class   (lc),
    .i_redirect    (redirect),
    .o_stall_if    (stall_if),
    .o_stall_id    (stall_id),
    .o_flush_id_ex (flush_id_ex),
    .o_flush_if_id (flush_if_id),
    .o_mul_busy    (mul_busy),
    .o_pending     (pending)
  );

  int npass = 0, nfail = 0, ntot = 0;
  int cyc = 0;
  int ready [NR];   // first cycle at which register r is no longer pending
  int mul_ready;    // first cycle at which the MUL unit is idle

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int rem(input int r);
    return (ready[r] > cyc) ? ready[r] - cyc : 0;
  endfunction

  function automatic int lat(input int c);
    return (c == 0) ? 1 : (c == 1) ? 2 : (c == 2) ? 3 : 0;
  endfunction

  task automatic clear_model();
    for (int r = 0; r < NR; r++) ready[r] = 0;
    mul_ready = 0;
  endtask

  // One ID cycle: drive, compare against the model, then advance the model if it issued.
  task automatic step(input bit v, input int s1, input int s2, input bit u1, input bit u2,
                      input bit isb, input bit isj, input int d, input bit we, input int c,
                      input bit redir, output bit dut_stall);
    bit ex, br, st, s;
    logic [31:0] pend;
    id_valid = v; rs1 = 5'(s1); rs2 = 5'(s2); use_rs1 = u1; use_rs2 = u2;
    is_branch = isb; is_jump = isj; rd = 5'(d); reg_write = we;
    lc = lat_class_e'(c); redirect = redir;
    #2;
    ex = 0; br = 0;
    if (u1 && s1 != 0) begin ex |= rem(s1) > EXT; br |= rem(s1) > 0; end
    if (u2 && s2 != 0) begin ex |= rem(s2) > EXT; br |= rem(s2) > 0; end
    st = (c == 2) && (mul_ready - cyc > 1);
    s = v && (ex || ((isb || isj) && br) || st);
    pend = '0;
    for (int r = 1; r < NR; r++) pend[r] = rem(r) > 0;
    chk("stall_if", 32'(stall_if), 32'(s));
    chk("stall_id", 32'(stall_id), 32'(s));
    chk("flush_id_ex", 32'(flush_id_ex), 32'(s));
    chk("flush_if_id", 32'(flush_if_id), 32'(redir && !s));
    chk("mul_busy", 32'(mul_busy), 32'(mul_ready > cyc));
    chk("pending", pending, pend);
    dut_stall = stall_id;
    if (v && !s) begin
      if (we && d != 0 && c != 3) ready[d] = cyc + 1 + lat(c) + ADJ;
      if (c == 2) mul_ready = cyc + 1 + 3;
    end
    @(posedge clk); #1;
    cyc++;
  endtask

  // Hold one instruction in ID until it issues; returns the number of stalled cycles.
  task automatic issue(input int d, input int s1, input int s2, input bit u1, input bit u2,
                       input bit isb, input bit isj, input bit we, input int c,
                       input bit redir, output int nst);
    bit st;
    nst = 0;
    step(1, s1, s2, u1, u2, isb, isj, d, we, c, redir, st);
    while (st && nst < 20) begin
      nst++;
      step(1, s1, s2, u1, u2, isb, isj, d, we, c, redir, st);
    end
    chk("issue_done", 32'(st), 32'd0);
  endtask

  task automatic idle(input int n);
    bit st;
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 3, 0, st);
  endtask

  initial begin
    int nst;
    bit st;
    clear_model();
    rst = 1'b1;
    id_valid = 0; rs1 = 0; rs2 = 0; use_rs1 = 0; use_rs2 = 0; is_branch = 0;
    is_jump = 0; rd = 0; reg_write = 0; lc = LC_NONE; redirect = 0;
    #12;
    chk("rst_pending", pending, 32'd0);
    chk("rst_stall", 32'(stall_id), 32'd0);
    chk("rst_mul_busy", 32'(mul_busy), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Reset mid-run while x5 is pending
    issue(5, 0, 0, 0, 0, 0, 0, 1, 1, 0, nst);
    idle(1);
    chk("pre_rst_pending5", 32'(pending[5]), 32'd1);
    id_valid = 1; rs1 = 5; use_rs1 = 1; use_rs2 = 0; rd = 6; reg_write = 1; lc = LC_ALU;
    #1 rst = 1'b1;
    #1;
    chk("midrst_pending", pending, 32'd0);
    chk("midrst_stall", 32'(stall_id), 32'd0);
    clear_model();
    @(posedge clk); #1;
    rst = 1'b0;
    cyc++;
    issue(6, 5, 1, 1, 1, 0, 0, 1, 0, 0, nst);
    chk("post_rst_stalls", nst, 0);
    idle(8);

    // LOAD -> ALU
    issue(5, 0, 0, 0, 0, 0, 0, 1, 1, 0, nst);
    issue(6, 5, 1, 1, 1, 0, 0, 1, 0, 0, nst);
    chk("ld_alu_stalls", nst, E_LD_ALU);
    idle(8);

    // ALU -> branch, LOAD -> branch
    issue(7, 0, 0, 0, 0, 0, 0, 1, 0, 0, nst);
    issue(0, 7, 0, 1, 1, 1, 0, 0, 3, 0, nst);
    chk("alu_br_stalls", nst, E_ALU_BR);
    idle(8);
    issue(7, 0, 0, 0, 0, 0, 0, 1, 1, 0, nst);
    issue(0, 7, 0, 1, 1, 1, 0, 0, 3, 0, nst);
    chk("ld_br_stalls", nst, E_LD_BR);
    idle(8);

    // MUL structural hazard and MUL -> ALU
    issue(8, 0, 0, 0, 0, 0, 0, 1, 2, 0, nst);
    issue(9, 0, 0, 0, 0, 0, 0, 1, 2, 0, nst);
    chk("mul_mul_stalls", nst, 2);
    idle(8);
    issue(8, 0, 0, 0, 0, 0, 0, 1, 2, 0, nst);
    issue(10, 8, 0, 1, 0, 0, 0, 1, 0, 0, nst);
    chk("mul_alu_stalls", nst, E_MUL_ALU);
    idle(8);

    // WAW newest-wins, and writes to x0
    issue(5, 0, 0, 0, 0, 0, 0, 1, 2, 0, nst);
    issue(5, 0, 0, 1, 0, 0, 0, 1, 0, 0, nst);
    issue(11, 5, 0, 1, 0, 0, 0, 1, 0, 0, nst);
    chk("waw_stalls", nst, E_WAW);
    issue(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, nst);
    chk("x0_pending", 32'(pending[0]), 32'd0);
    idle(8);

    // Redirect with and without a stall
    issue(0, 0, 0, 0, 0, 0, 1, 0, 3, 1, nst);
    issue(5, 0, 0, 0, 0, 0, 0, 1, 1, 0, nst);
    issue(0, 5, 0, 1, 0, 1, 0, 0, 3, 1, nst);
    chk("redir_stalls", nst, E_LD_BR);
    idle(8);

    // Randomized traffic on a small register window
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 9) != 0,
           int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
           $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
           $urandom_range(0, 4) == 0, $urandom_range(0, 9) == 0,
           int'($urandom_range(0, 7)), $urandom_range(0, 4) != 0,
           int'($urandom_range(0, 3)), $urandom_range(0, 4) == 0, st);
    end

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
